// File: rtl/pixel_prefetch_scheduler.sv
// pixel_prefetch_scheduler
// Prefetches 8-bit colour indices from the frame buffer into a small FIFO
// and hands one index per active pixel strobe to the palette, registered on
// colorIndex. One memory request is outstanding at a time.
//
// Optional feature: define PREFETCH_STATS_EN to add underflow_cnt[15:0], a
// saturating count of pops that found the FIFO empty.
//
// Memory handshake: mem_req rises with mem_addr and both stay constant until
// the cycle mem_ack is sampled high; mem_rdata is taken in that same cycle.
// A request is never withdrawn once raised (only Reset drops it), so a
// frame_start that lands mid-request parks the FSM in DISCARD until the ack
// arrives and the returned word is thrown away.
//
// dbg_state exposes the FSM state (0=IDLE, 1=FETCH, 2=DISCARD) for checkers.

module pixel_prefetch_scheduler #(
    parameter int          DEPTH     = 16,
    parameter int          ADDR_W    = 19,
    parameter int          H_RES     = 640,
    parameter int          V_RES     = 480,
    parameter logic [7:0]  BLANK_IDX = 8'hFF
) (
    input  logic                      Clk,
    input  logic                      Reset,
    input  logic                      frame_start,
    input  logic                      pixel_en,
    input  logic                      active,
    output logic                      mem_req,
    output logic [ADDR_W-1:0]         mem_addr,
    input  logic                      mem_ack,
    input  logic [7:0]                mem_rdata,
    output logic [7:0]                colorIndex,
    output logic [$clog2(DEPTH):0]    fifo_count,
    output logic                      underflow,
`ifdef PREFETCH_STATS_EN
    output logic [15:0]               underflow_cnt,
`endif
    output logic [1:0]                dbg_state
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0]  DEPTH_CNT = CNT_W'(DEPTH);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(H_RES * V_RES - 1);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_FETCH   = 2'd1,
        S_DISCARD = 2'd2
    } state_t;

    state_t             state;
    state_t             state_nxt;

    logic [ADDR_W-1:0]  addr_cnt;
    logic [7:0]         fifo_mem [0:DEPTH-1];
    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W-1:0]   rd_ptr;

    logic               fifo_empty;
    logic               push;
    logic               pop_req;
    logic               pop;
    logic               under_hit;
    logic               launch;

    // Event decode: frame_start suppresses push and pop in its own cycle.
    always_comb begin
        fifo_empty = (fifo_count == '0);
        push       = (state == S_FETCH) && mem_ack && !frame_start;
        pop_req    = pixel_en && active && !frame_start;
        pop        = pop_req && !fifo_empty;
        under_hit  = pop_req && fifo_empty;
        launch     = (state == S_IDLE) && (state_nxt == S_FETCH);
    end

    // FSM state register.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // FSM next state. Nothing is pending while IDLE, so the free-slot test
    // reduces to the registered occupancy being below DEPTH; a pop landing in
    // the same cycle only makes this conservative.
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (!frame_start && (fifo_count < DEPTH_CNT)) begin
                    state_nxt = S_FETCH;
                end
            end
            S_FETCH: begin
                if (mem_ack) begin
                    state_nxt = S_IDLE;
                end else if (frame_start) begin
                    state_nxt = S_DISCARD;
                end
            end
            S_DISCARD: begin
                if (mem_ack) begin
                    state_nxt = S_IDLE;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // Request is decoded from state so an async Reset drops it at once.
    always_comb begin
        mem_req   = (state == S_FETCH) || (state == S_DISCARD);
        dbg_state = state;
    end

    // Request address is captured at launch so it stays put through DISCARD
    // even though frame_start rewinds addr_cnt underneath it.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            mem_addr <= '0;
        end else if (launch) begin
            mem_addr <= addr_cnt;
        end
    end

    // Frame-buffer read address: advances per stored word, wraps at the end
    // of the active raster, rewinds on frame_start.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            addr_cnt <= '0;
        end else if (frame_start) begin
            addr_cnt <= '0;
        end else if (push) begin
            if (addr_cnt == LAST_ADDR) begin
                addr_cnt <= '0;
            end else begin
                addr_cnt <= addr_cnt + ADDR_W'(1);
            end
        end
    end

    // FIFO storage; contents need no reset since occupancy guards reads.
    always_ff @(posedge Clk) begin
        if (push) begin
            fifo_mem[wr_ptr] <= mem_rdata;
        end
    end

    // FIFO pointers and occupancy; frame_start flushes in one cycle.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
        end else if (frame_start) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   fifo_count <= fifo_count + CNT_W'(1);
                2'b01:   fifo_count <= fifo_count - CNT_W'(1);
                default: fifo_count <= fifo_count;
            endcase
        end
    end

    // Output index: head entry on a real pop, blank on blanking strobes or
    // an empty FIFO, otherwise hold. No bypass of a same-cycle push.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            colorIndex <= BLANK_IDX;
        end else if (pixel_en) begin
            if (pop) begin
                colorIndex <= fifo_mem[rd_ptr];
            end else begin
                colorIndex <= BLANK_IDX;
            end
        end
    end

    // Sticky underflow flag, cleared at the start of each frame.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            underflow <= 1'b0;
        end else if (frame_start) begin
            underflow <= 1'b0;
        end else if (under_hit) begin
            underflow <= 1'b1;
        end
    end

`ifdef PREFETCH_STATS_EN
    // Saturating count of empty pops, cleared at the start of each frame.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            underflow_cnt <= '0;
        end else if (frame_start) begin
            underflow_cnt <= '0;
        end else if (under_hit && (underflow_cnt != 16'hFFFF)) begin
            underflow_cnt <= underflow_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_pixel_prefetch_scheduler.sv
// Testbench for pixel_prefetch_scheduler. A small raster (10x5) is used so
// the end-of-frame address wrap is reachable in a short run.
`timescale 1ns/1ps

module tb_pixel_prefetch_scheduler;

    localparam int DEPTH  = 16;
    localparam int ADDR_W = 19;
    localparam int H_RES  = 10;
    localparam int V_RES  = 5;
    localparam int LAST   = H_RES * V_RES - 1;

    logic              Clk;
    logic              Reset;
    logic              frame_start;
    logic              pixel_en;
    logic              active;
    logic              mem_req;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_ack = 1'b0;
    logic [7:0]        mem_rdata = 8'h00;
    logic [7:0]        colorIndex;
    logic [4:0]        fifo_count;
    logic              underflow;
    logic [1:0]        dbg_state;
`ifdef PREFETCH_STATS_EN
    logic [15:0]       underflow_cnt;
`endif

    int n_vec;
    int n_err;

    logic [7:0]        exp_q[$];
    logic [ADDR_W-1:0] addr_log[$];

    // memory responder controls (written by the stimulus block only)
    int  lat;
    bit  stall;
    int  ack_req_cnt;
    // responder-owned
    int  ack_done_cnt;
    int  wait_cnt;

    int  next_exp;
    int  base;

    pixel_prefetch_scheduler #(
        .DEPTH(DEPTH), .ADDR_W(ADDR_W), .H_RES(H_RES), .V_RES(V_RES),
        .BLANK_IDX(8'hFF)
    ) dut (
        .Clk(Clk),
        .Reset(Reset),
        .frame_start(frame_start),
        .pixel_en(pixel_en),
        .active(active),
        .mem_req(mem_req),
        .mem_addr(mem_addr),
        .mem_ack(mem_ack),
        .mem_rdata(mem_rdata),
        .colorIndex(colorIndex),
        .fifo_count(fifo_count),
        .underflow(underflow),
`ifdef PREFETCH_STATS_EN
        .underflow_cnt(underflow_cnt),
`endif
        .dbg_state(dbg_state)
    );

    // clock
    initial begin
        Clk = 1'b0;
        forever #5 Clk = ~Clk;
    end

    // watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: run did not finish, got timeout, want finish");
        $fatal(1);
    end

    // Memory model: returns addr[7:0] as data after lat cycles of mem_req,
    // or immediately when the stimulus block requests a manual ack.
    always @(negedge Clk) begin
        if (mem_ack) begin
            mem_ack = 1'b0;
        end else if (mem_req && (ack_req_cnt != ack_done_cnt)) begin
            mem_ack   = 1'b1;
            mem_rdata = mem_addr[7:0];
            addr_log.push_back(mem_addr);
            ack_done_cnt++;
            wait_cnt = 0;
        end else if (mem_req && !stall) begin
            wait_cnt++;
            if (wait_cnt >= lat) begin
                mem_ack   = 1'b1;
                mem_rdata = mem_addr[7:0];
                addr_log.push_back(mem_addr);
                wait_cnt = 0;
            end
        end
        if (!mem_req) wait_cnt = 0;
    end

    function automatic int adv(input int a);
        return (a == LAST) ? 0 : a + 1;
    endfunction

    // one pixel strobe, inputs driven mid-cycle, returns #1 after the edge
    task automatic drive_pop(input bit act);
        @(negedge Clk);
        pixel_en = 1'b1;
        active   = act;
        @(posedge Clk);
        #1;
        pixel_en = 1'b0;
        active   = 1'b0;
    endtask

    task automatic test_reset();
        Reset = 1'b1; frame_start = 1'b0; pixel_en = 1'b0; active = 1'b0;
        stall = 1'b1; lat = 2; ack_req_cnt = 0;
        repeat (3) @(posedge Clk);
        #1;
        n_vec++; if (mem_req !== 1'b0) begin n_err++; $display("FAIL reset_mem_req got %b want 0", mem_req); end
        n_vec++; if (mem_addr !== '0) begin n_err++; $display("FAIL reset_mem_addr got %0d want 0", mem_addr); end
        n_vec++; if (colorIndex !== 8'hFF) begin n_err++; $display("FAIL reset_color got %h want ff", colorIndex); end
        n_vec++; if (fifo_count !== 5'd0) begin n_err++; $display("FAIL reset_count got %0d want 0", fifo_count); end
        n_vec++; if (underflow !== 1'b0) begin n_err++; $display("FAIL reset_underflow got %b want 0", underflow); end
        n_vec++; if (dbg_state !== 2'd0) begin n_err++; $display("FAIL reset_state got %0d want 0", dbg_state); end
        @(negedge Clk);
        Reset = 1'b0;
    endtask

    task automatic test_fill();
        int hi;
        base  = addr_log.size();
        lat   = 2;
        stall = 1'b0;
        for (int i = 0; i < 400 && fifo_count != 5'd16; i++) @(posedge Clk);
        #1;
        n_vec++; if (fifo_count !== 5'd16) begin n_err++; $display("FAIL fill_count got %0d want 16", fifo_count); end
        for (int i = 0; i < 16; i++) begin
            n_vec++;
            if (addr_log.size() <= base + i) begin
                n_err++; $display("FAIL fill_addr[%0d] got none want %0d", i, i);
            end else if (addr_log[base+i] !== ADDR_W'(i)) begin
                n_err++; $display("FAIL fill_addr[%0d] got %0d want %0d", i, addr_log[base+i], i);
            end
        end
        hi = 0;
        repeat (10) begin
            @(posedge Clk); #1;
            if (mem_req) hi++;
        end
        n_vec++; if (hi != 0) begin n_err++; $display("FAIL full_no_req got %0d req cycles want 0", hi); end
        n_vec++; if (addr_log.size() != base + 16) begin n_err++; $display("FAIL full_fetches got %0d want %0d", addr_log.size() - base, 16); end
    endtask

    task automatic test_drain();
        logic [7:0] got;
        logic [7:0] want;
        stall = 1'b1;
        next_exp = 0;
        for (int i = 0; i < 16; i++) begin
            exp_q.push_back(8'(next_exp));
            next_exp = adv(next_exp);
            drive_pop(1'b1);
            got  = colorIndex;
            want = exp_q.pop_front();
            n_vec++; if (got !== want) begin n_err++; $display("FAIL drain_pop[%0d] got %h want %h", i, got, want); end
        end
        n_vec++; if (fifo_count !== 5'd0) begin n_err++; $display("FAIL drain_count got %0d want 0", fifo_count); end
        n_vec++; if (underflow !== 1'b0) begin n_err++; $display("FAIL drain_underflow got %b want 0", underflow); end
    endtask

    task automatic test_underflow();
        drive_pop(1'b1);
        n_vec++; if (colorIndex !== 8'hFF) begin n_err++; $display("FAIL uf_color got %h want ff", colorIndex); end
        n_vec++; if (underflow !== 1'b1) begin n_err++; $display("FAIL uf_flag got %b want 1", underflow); end
        n_vec++; if (fifo_count !== 5'd0) begin n_err++; $display("FAIL uf_count got %0d want 0", fifo_count); end
`ifdef PREFETCH_STATS_EN
        n_vec++; if (underflow_cnt !== 16'd1) begin n_err++; $display("FAIL uf_cnt1 got %0d want 1", underflow_cnt); end
`endif
        drive_pop(1'b1);
        n_vec++; if (underflow !== 1'b1) begin n_err++; $display("FAIL uf_sticky got %b want 1", underflow); end
`ifdef PREFETCH_STATS_EN
        n_vec++; if (underflow_cnt !== 16'd2) begin n_err++; $display("FAIL uf_cnt2 got %0d want 2", underflow_cnt); end
`endif
    endtask

    task automatic test_discard();
        // the request for address 16 is stalled in FETCH
        @(negedge Clk);
        frame_start = 1'b1;
        @(posedge Clk); #1;
        n_vec++; if (fifo_count !== 5'd0) begin n_err++; $display("FAIL fs_count got %0d want 0", fifo_count); end
        n_vec++; if (underflow !== 1'b0) begin n_err++; $display("FAIL fs_underflow got %b want 0", underflow); end
        n_vec++; if (dbg_state !== 2'd2) begin n_err++; $display("FAIL fs_state got %0d want 2", dbg_state); end
        n_vec++; if (mem_req !== 1'b1) begin n_err++; $display("FAIL fs_req_held got %b want 1", mem_req); end
        n_vec++; if (mem_addr !== ADDR_W'(16)) begin n_err++; $display("FAIL fs_addr_stable got %0d want 16", mem_addr); end
`ifdef PREFETCH_STATS_EN
        n_vec++; if (underflow_cnt !== 16'd0) begin n_err++; $display("FAIL fs_cnt got %0d want 0", underflow_cnt); end
`endif
        base = addr_log.size();
        @(negedge Clk);
        frame_start = 1'b0;
        lat   = 3;
        stall = 1'b0;
        for (int i = 0; i < 50 && addr_log.size() <= base; i++) @(posedge Clk);
        #1;
        n_vec++;
        if (addr_log.size() <= base) begin
            n_err++; $display("FAIL discard_ack got none want ack");
        end else if (addr_log[base] !== ADDR_W'(16)) begin
            n_err++; $display("FAIL discard_addr got %0d want 16", addr_log[base]);
        end
        n_vec++; if (fifo_count !== 5'd0) begin n_err++; $display("FAIL discard_no_push got %0d want 0", fifo_count); end
        for (int i = 0; i < 50 && addr_log.size() <= base + 1; i++) @(posedge Clk);
        #1;
        n_vec++;
        if (addr_log.size() <= base + 1) begin
            n_err++; $display("FAIL restart_addr got none want 0");
        end else if (addr_log[base+1] !== '0) begin
            n_err++; $display("FAIL restart_addr got %0d want 0", addr_log[base+1]);
        end
        for (int i = 0; i < 400 && fifo_count != 5'd16; i++) @(posedge Clk);
        #1;
        n_vec++; if (fifo_count !== 5'd16) begin n_err++; $display("FAIL refill_count got %0d want 16", fifo_count); end
        base = base + 1;
    endtask

    task automatic test_wrap_stream();
        logic [7:0] got;
        logic [7:0] want;
        int e;
        int bad;
        lat = 1;
        next_exp = 0;
        for (int i = 0; i < 70; i++) begin
            exp_q.push_back(8'(next_exp));
            next_exp = adv(next_exp);
            drive_pop(1'b1);
            got  = colorIndex;
            want = exp_q.pop_front();
            n_vec++; if (got !== want) begin n_err++; $display("FAIL stream_pop[%0d] got %h want %h", i, got, want); end
            repeat (2) @(posedge Clk);
        end
        e = 0;
        bad = 0;
        for (int i = base; i < addr_log.size(); i++) begin
            if (addr_log[i] !== ADDR_W'(e)) begin
                if (bad == 0) $display("FAIL wrap_addr[%0d] got %0d want %0d", i - base, addr_log[i], e);
                bad++;
            end
            e = adv(e);
        end
        n_vec++; if (bad != 0) begin n_err++; $display("FAIL wrap_sequence got %0d bad want 0", bad); end
        n_vec++; if (addr_log.size() - base <= LAST + 1) begin n_err++; $display("FAIL wrap_reached got %0d fetches want >%0d", addr_log.size() - base, LAST + 1); end
        n_vec++; if (underflow !== 1'b0) begin n_err++; $display("FAIL stream_underflow got %b want 0", underflow); end
    endtask

    task automatic test_push_pop();
        logic [7:0] got;
        logic [7:0] want;
        @(negedge Clk);
        stall = 1'b1;
        repeat (3) @(posedge Clk);
        #1;
        for (int i = 0; i < 20 && fifo_count > 5'd5; i++) begin
            exp_q.push_back(8'(next_exp));
            next_exp = adv(next_exp);
            drive_pop(1'b1);
            got  = colorIndex;
            want = exp_q.pop_front();
            n_vec++; if (got !== want) begin n_err++; $display("FAIL pp_drain[%0d] got %h want %h", i, got, want); end
        end
        n_vec++; if (fifo_count !== 5'd5) begin n_err++; $display("FAIL pp_pre_count got %0d want 5", fifo_count); end
        n_vec++; if (mem_req !== 1'b1) begin n_err++; $display("FAIL pp_pending got %b want 1", mem_req); end
        // ack lands in the same cycle as the strobe
        ack_req_cnt++;
        exp_q.push_back(8'(next_exp));
        next_exp = adv(next_exp);
        drive_pop(1'b1);
        got  = colorIndex;
        want = exp_q.pop_front();
        n_vec++; if (fifo_count !== 5'd5) begin n_err++; $display("FAIL pp_count got %0d want 5", fifo_count); end
        n_vec++; if (got !== want) begin n_err++; $display("FAIL pp_pop got %h want %h", got, want); end
        // blanking strobe: blank index, no pop
        drive_pop(1'b0);
        n_vec++; if (colorIndex !== 8'hFF) begin n_err++; $display("FAIL blank_color got %h want ff", colorIndex); end
        n_vec++; if (fifo_count !== 5'd5) begin n_err++; $display("FAIL blank_count got %0d want 5", fifo_count); end
        for (int i = 0; i < 5; i++) begin
            exp_q.push_back(8'(next_exp));
            next_exp = adv(next_exp);
            drive_pop(1'b1);
            got  = colorIndex;
            want = exp_q.pop_front();
            n_vec++; if (got !== want) begin n_err++; $display("FAIL pp_order[%0d] got %h want %h", i, got, want); end
        end
        n_vec++; if (fifo_count !== 5'd0) begin n_err++; $display("FAIL pp_final_count got %0d want 0", fifo_count); end
    endtask

    task automatic test_reset_mid();
        repeat (3) @(posedge Clk);
        #1;
        n_vec++; if (mem_req !== 1'b1) begin n_err++; $display("FAIL mid_pre_req got %b want 1", mem_req); end
        @(posedge Clk);
        #2;
        Reset = 1'b1;
        #1;
        n_vec++; if (mem_req !== 1'b0) begin n_err++; $display("FAIL mid_req_drop got %b want 0", mem_req); end
        n_vec++; if (dbg_state !== 2'd0) begin n_err++; $display("FAIL mid_state got %0d want 0", dbg_state); end
        n_vec++; if (colorIndex !== 8'hFF) begin n_err++; $display("FAIL mid_color got %h want ff", colorIndex); end
        @(negedge Clk);
        Reset = 1'b0;
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        test_reset();
        test_fill();
        test_drain();
        test_underflow();
        test_discard();
        test_wrap_stream();
        test_push_pop();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
